// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and index-width helper
package regfile_pkg;
  localparam int ZERO_IDX = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v >>= 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/busy_scoreboard.sv
// busy_scoreboard: per-register pending-producer bits with issue > flush > write-clear priority
module busy_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W = clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                ctrl_writeEnable,
  input  logic [ADDR_W-1:0]   ctrl_writeReg,
  input  logic                ctrl_issueEnable,
  input  logic [ADDR_W-1:0]   ctrl_issueReg,
  input  logic                ctrl_flush,
  output logic [NUM_REGS-1:0] busyNext,
  output logic                busy_any
);
  logic [NUM_REGS-1:0] busy;
  always_comb begin
    busyNext = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busyNext[i] = (ctrl_reset || i == ZERO_IDX) ? 1'b0 :
                    (ctrl_issueEnable && ctrl_issueReg == ADDR_W'(i)) ? 1'b1 :
                    (ctrl_flush || (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(i))) ? 1'b0 :
                    busy[i];
  end
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy <= '0;
      busy_any <= 1'b0;
    end else begin
      busy <= busyNext;
      busy_any <= |busyNext;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write-to-read bypass and RAW busy scoreboard
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic                     ctrl_issueEnable,
  input  logic [ADDR_W-1:0]        ctrl_issueReg,
  input  logic                     ctrl_flush,
  input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
  output logic [NUM_RD*DATA_W-1:0] data_readReg,
  output logic [NUM_RD-1:0]        data_readBusy,
  output logic                     busy_any
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busyNext;
  always_ff @(posedge clock) begin
    if (ctrl_reset) regs <= '{default: '0};
    else if (ctrl_writeEnable && ctrl_writeReg != ADDR_W'(ZERO_IDX)) regs[ctrl_writeReg] <= data_writeReg;
  end
  busy_scoreboard #(.NUM_REGS(NUM_REGS)) sb (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .ctrl_issueEnable(ctrl_issueEnable),
    .ctrl_issueReg(ctrl_issueReg),
    .ctrl_flush(ctrl_flush),
    .busyNext(busyNext),
    .busy_any(busy_any)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    always_comb begin
      idx = ctrl_readReg[k*ADDR_W +: ADDR_W];
      data_readReg[k*DATA_W +: DATA_W] = (idx == ADDR_W'(ZERO_IDX)) ? '0 :
        (ctrl_writeEnable && ctrl_writeReg == idx) ? data_writeReg :
        ctrl_reset ? '0 : regs[idx];
      data_readBusy[k] = busyNext[idx];
    end
  end
endmodule
